// File: rtl/register_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// Latency: n/a (package). Backpressure: n/a.
// Contents: default geometry, word/select types, byte-enable merge used by write path and bypass.
package register_file_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_SEL_WIDTH = 8;
  localparam int DEF_DEPTH     = 16;

  // byte_merge works on a fixed wide container so that every WIDTH
  // instantiation can share one function; callers extend and truncate.
  localparam int MAX_WIDTH = 256;
  localparam int MAX_BE    = MAX_WIDTH / 8;

  typedef logic [DEF_WIDTH-1:0]     word_t;
  typedef logic [DEF_SEL_WIDTH-1:0] sel_t;
  typedef logic [MAX_WIDTH-1:0]     wide_t;
  typedef logic [MAX_BE-1:0]        wide_be_t;

  // Bytes with be=1 come from new_w, the rest keep old_w.
  function automatic wide_t byte_merge(input wide_t old_w, input wide_t new_w, input wide_be_t be);
    wide_t r;
    r = old_w;
    for (int k = 0; k < MAX_BE; k++) begin
      if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Control-unit side bundle of the register file: write port, read selects, reservations, busy flags.
// Latency: wires only. Backpressure: none, all signals are level-sampled.
// master = control unit (drives requests), slave = register file (returns busy/busy_any).
interface register_file_mp_if #(
  parameter int WIDTH     = register_file_pkg::DEF_WIDTH,
  parameter int SEL_WIDTH = register_file_pkg::DEF_SEL_WIDTH,
  parameter int NUM_READ  = 2
);
  logic                          ld;
  logic [SEL_WIDTH-1:0]          sel_ld;
  logic [WIDTH/8-1:0]            be;
  logic [WIDTH-1:0]              input_bus;
  logic [NUM_READ-1:0]           oe;
  logic [NUM_READ*SEL_WIDTH-1:0] sel;
  logic                          reserve;
  logic [SEL_WIDTH-1:0]          sel_rsv;
  logic [NUM_READ-1:0]           busy;
  logic                          busy_any;

  modport master (
    output ld, sel_ld, be, input_bus, oe, sel, reserve, sel_rsv,
    input  busy, busy_any
  );

  modport slave (
    input  ld, sel_ld, be, input_bus, oe, sel, reserve, sel_rsv,
    output busy, busy_any
  );
endinterface

// File: rtl/register_file_read_port.sv
// One tri-state read port: selects a register (or the bypassed write data) and drives its bus slice.
// Latency: combinational. Backpressure: none; oe_i=0 releases the slice.
// Ports: regs_i array view, ld_i/sel_ld_i/be_i/input_bus_i write side, oe_i, sel_i, bus_o slice.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SEL_WIDTH = DEF_SEL_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BYPASS    = 1
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] regs_i,
  input  logic                        ld_i,
  input  logic [SEL_WIDTH-1:0]        sel_ld_i,
  input  logic [WIDTH/8-1:0]          be_i,
  input  logic [WIDTH-1:0]            input_bus_i,
  input  logic                        oe_i,
  input  logic [SEL_WIDTH-1:0]        sel_i,
  output wire  [WIDTH-1:0]            bus_o
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             rd_hit;
  logic             byp_hit;
  logic [WIDTH-1:0] old_dat;
  logic [WIDTH-1:0] rd_dat;

  assign rd_hit  = 32'(sel_i) < 32'(DEPTH);
  assign old_dat = regs_i[sel_i[IDX_W-1:0]];
  // Forward only when the write actually lands in the register being read.
  assign byp_hit = (BYPASS != 0) && ld_i && (sel_ld_i == sel_i) && rd_hit;

  always_comb begin
    rd_dat = '0;
    if (rd_hit) begin
      if (byp_hit) rd_dat = WIDTH'(byte_merge(MAX_WIDTH'(old_dat), MAX_WIDTH'(input_bus_i), MAX_BE'(be_i)));
      else         rd_dat = old_dat;
    end
  end

  assign bus_o = oe_i ? rd_dat : {WIDTH{1'bz}};
endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: one byte-enabled write port, NUM_READ tri-state read ports, busy scoreboard.
// Latency: reads combinational (optional same-cycle bypass), writes/reservations land at posedge.
// Backpressure: none; out-of-range addresses are ignored, hazards are exposed through busy/busy_any.
// Ports: clk, rst (async, active high), rf (slave side of register_file_mp_if), bus (packed tri-state read slices).
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               SEL_WIDTH   = DEF_SEL_WIDTH,
  parameter int               DEPTH       = DEF_DEPTH,
  parameter int               NUM_READ    = 2,
  parameter int               BYPASS      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  register_file_mp_if.slave         rf,
  inout  wire [NUM_READ*WIDTH-1:0]  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]            busy_q, busy_d;
  logic                        ld_hit, rsv_hit;
  logic [IDX_W-1:0]            ld_idx, rsv_idx;
  logic [NUM_READ-1:0]         busy_w;
  logic [SEL_WIDTH-1:0]        port_sel;

  assign ld_hit  = rf.ld      && (32'(rf.sel_ld)  < 32'(DEPTH));
  assign rsv_hit = rf.reserve && (32'(rf.sel_rsv) < 32'(DEPTH));
  assign ld_idx  = rf.sel_ld[IDX_W-1:0];
  assign rsv_idx = rf.sel_rsv[IDX_W-1:0];

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (ld_hit) begin
      regs_d[ld_idx] = WIDTH'(byte_merge(MAX_WIDTH'(regs_q[ld_idx]), MAX_WIDTH'(rf.input_bus), MAX_BE'(rf.be)));
      busy_d[ld_idx] = 1'b0;
    end
    // Applied after the clear so a new producer reserving the register
    // being retired on the same edge keeps it busy.
    if (rsv_hit) busy_d[rsv_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= {DEPTH{RESET_VALUE}};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Busy lookup ignores oe so the control unit can probe without driving the bus.
  always_comb begin
    busy_w   = '0;
    port_sel = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      port_sel = rf.sel[i*SEL_WIDTH +: SEL_WIDTH];
      if (32'(port_sel) < 32'(DEPTH)) busy_w[i] = busy_q[port_sel[IDX_W-1:0]];
    end
  end

  assign rf.busy     = busy_w;
  assign rf.busy_any = |busy_q;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_port
    register_file_read_port #(
      .WIDTH     (WIDTH),
      .SEL_WIDTH (SEL_WIDTH),
      .DEPTH     (DEPTH),
      .BYPASS    (BYPASS)
    ) u_port (
      .regs_i      (regs_q),
      .ld_i        (rf.ld),
      .sel_ld_i    (rf.sel_ld),
      .be_i        (rf.be),
      .input_bus_i (rf.input_bus),
      .oe_i        (rf.oe[i]),
      .sel_i       (rf.sel[i*SEL_WIDTH +: SEL_WIDTH]),
      .bus_o       (bus[i*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: BYPASS=1 and BYPASS=0 instances driven in lockstep.
// Released bus slices are pulled high, so "not driving" reads as all ones.
module tb_register_file_mp;
  import register_file_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  ld = 1'b0;
  sel_t  sel_ld = '0;
  logic [3:0] be = '0;
  word_t din = '0;
  logic [1:0] oe = '0;
  sel_t  sel0 = '0, sel1 = '0;
  logic  reserve = 1'b0;
  sel_t  sel_rsv = '0;

  tri1 [63:0] bus_a;
  tri1 [63:0] bus_b;

  int checks = 0;
  int errors = 0;

  word_t      m_reg [16];
  logic [15:0] m_busy;

  always #5 clk = ~clk;

  register_file_mp_if ifa ();
  register_file_mp_if ifb ();

  assign ifa.ld = ld;       assign ifb.ld = ld;
  assign ifa.sel_ld = sel_ld; assign ifb.sel_ld = sel_ld;
  assign ifa.be = be;       assign ifb.be = be;
  assign ifa.input_bus = din; assign ifb.input_bus = din;
  assign ifa.oe = oe;       assign ifb.oe = oe;
  assign ifa.sel = {sel1, sel0}; assign ifb.sel = {sel1, sel0};
  assign ifa.reserve = reserve; assign ifb.reserve = reserve;
  assign ifa.sel_rsv = sel_rsv; assign ifb.sel_rsv = sel_rsv;

  register_file_mp #(.BYPASS(1)) dut_a (.clk(clk), .rst(rst), .rf(ifa), .bus(bus_a));
  register_file_mp #(.BYPASS(0)) dut_b (.clk(clk), .rst(rst), .rf(ifb), .bus(bus_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic l, input sel_t sl, input logic [3:0] b, input word_t d,
                       input logic [1:0] o, input sel_t s0, input sel_t s1,
                       input logic r, input sel_t sr);
    ld = l; sel_ld = sl; be = b; din = d; oe = o; sel0 = s0; sel1 = s1; reserve = r; sel_rsv = sr;
  endtask

  // Reference model: registers as an array, byte enables as a mask.
  function automatic word_t merge_m(input word_t o, input word_t n, input logic [3:0] b);
    word_t m;
    m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic word_t exp_bus(input logic en, input sel_t s, input bit byp);
    if (!en) return 32'hFFFF_FFFF;
    if (s >= 16) return 32'h0;
    if (byp && ld && sel_ld == s) return merge_m(m_reg[s[3:0]], din, be);
    return m_reg[s[3:0]];
  endfunction

  function automatic logic exp_busy(input sel_t s);
    return (s < 16) ? m_busy[s[3:0]] : 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_busy = '0;
  endtask

  task automatic model_edge();
    if (ld && sel_ld < 16) begin
      m_reg[sel_ld[3:0]]  = merge_m(m_reg[sel_ld[3:0]], din, be);
      m_busy[sel_ld[3:0]] = 1'b0;
    end
    if (reserve && sel_rsv < 16) m_busy[sel_rsv[3:0]] = 1'b1;
  endtask

  typedef struct {
    logic       ld;
    sel_t       sel_ld;
    logic [3:0] be;
    word_t      din;
    logic [1:0] oe;
    sel_t       sel0, sel1;
    logic       rsv;
    sel_t       sel_rsv;
    word_t      e_bus0, e_bus1;
    logic [1:0] e_busy;
    logic       e_any;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b1, 8'd2,  4'hF,    32'h11223344, 2'b11, 8'd2, 8'd2,  1'b0, 8'd0,  32'h11223344, 32'h11223344, 2'b00, 1'b0};
    vecs[1] = '{1'b1, 8'd2,  4'b0101, 32'hAABBCCDD, 2'b11, 8'd2, 8'd2,  1'b0, 8'd0,  32'h11BB33DD, 32'h11BB33DD, 2'b00, 1'b0};
    vecs[2] = '{1'b0, 8'd0,  4'hF,    32'h0,        2'b11, 8'd7, 8'd2,  1'b1, 8'd7,  32'h0,        32'h11BB33DD, 2'b01, 1'b1};
    vecs[3] = '{1'b1, 8'd7,  4'hF,    32'd123,      2'b11, 8'd7, 8'd20, 1'b0, 8'd0,  32'd123,      32'h0,        2'b00, 1'b0};
    vecs[4] = '{1'b1, 8'd7,  4'hF,    32'h0000DEAD, 2'b11, 8'd7, 8'd7,  1'b1, 8'd7,  32'h0000DEAD, 32'h0000DEAD, 2'b11, 1'b1};
    vecs[5] = '{1'b1, 8'd16, 4'hF,    32'hFFFFFFFF, 2'b01, 8'd2, 8'd7,  1'b1, 8'd16, 32'h11BB33DD, 32'hFFFFFFFF, 2'b10, 1'b1};
    vecs[6] = '{1'b1, 8'd3,  4'hF,    32'd321,      2'b11, 8'd3, 8'd4,  1'b1, 8'd4,  32'd321,      32'h0,        2'b10, 1'b1};
    vecs[7] = '{1'b1, 8'd4,  4'h0,    32'hFFFFFFFF, 2'b11, 8'd4, 8'd3,  1'b0, 8'd0,  32'h0,        32'd321,      2'b00, 1'b1};
    vecs[8] = '{1'b1, 8'd7,  4'b1000, 32'h55000000, 2'b11, 8'd7, 8'd7,  1'b0, 8'd0,  32'h5500DEAD, 32'h5500DEAD, 2'b00, 1'b0};

    // Reset with no clock edge yet.
    #1 rst = 1'b1;
    drive(0, 0, 0, 0, 2'b01, 8'd3, 8'd0, 0, 0);
    #1;
    chk("rst_bus0",  bus_a[31:0],  32'h0);
    chk("rst_bus1_released", bus_a[63:32], 32'hFFFF_FFFF);
    chk("rst_busy",  {30'b0, ifa.busy}, 32'h0);
    chk("rst_any",   {31'b0, ifa.busy_any}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: write/reserve for one edge, then read back with ld/reserve low.
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      drive(vecs[v].ld, vecs[v].sel_ld, vecs[v].be, vecs[v].din, vecs[v].oe,
            vecs[v].sel0, vecs[v].sel1, vecs[v].rsv, vecs[v].sel_rsv);
      @(posedge clk);
      #1;
      ld = 1'b0; reserve = 1'b0;
      #1;
      chk($sformatf("vec%0d_bus0", v), bus_a[31:0],  vecs[v].e_bus0);
      chk($sformatf("vec%0d_bus1", v), bus_a[63:32], vecs[v].e_bus1);
      chk($sformatf("vec%0d_busy", v), {30'b0, ifa.busy}, {30'b0, vecs[v].e_busy});
      chk($sformatf("vec%0d_any", v),  {31'b0, ifa.busy_any}, {31'b0, vecs[v].e_any});
    end

    // Bypass: same-cycle forwarding vs old value until the edge.
    @(negedge clk);
    drive(1, 8'd5, 4'hF, 32'd123, 2'b11, 8'd5, 8'd5, 0, 0);
    #1;
    chk("byp_a0_same_cycle", bus_a[31:0],  32'd123);
    chk("byp_a1_same_cycle", bus_a[63:32], 32'd123);
    chk("nobyp_b0_old",      bus_b[31:0],  32'h0);
    @(posedge clk); #1; ld = 1'b0; #1;
    chk("nobyp_b0_after",    bus_b[31:0],  32'd123);
    @(negedge clk);
    drive(1, 8'd5, 4'b0010, 32'h0000AB00, 2'b11, 8'd5, 8'd5, 0, 0);
    #1;
    chk("byp_a0_partial",    bus_a[31:0],  32'h0000AB7B);
    chk("nobyp_b0_partial",  bus_b[31:0],  32'h0000007B);
    @(posedge clk); #1; ld = 1'b0; #1;
    chk("nobyp_b0_partial_after", bus_b[31:0], 32'h0000AB7B);

    // Reset between edges clears contents and busy at once; write during reset is lost.
    @(negedge clk);
    drive(1, 8'd4, 4'hF, 32'd567, 2'b00, 8'd4, 8'd7, 1, 8'd4);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 2'b11, 8'd4, 8'd7, 0, 0);
    #1;
    chk("pre_rst_reg4",  bus_a[31:0], 32'd567);
    chk("pre_rst_busy",  {30'b0, ifa.busy}, 32'h1);
    chk("pre_rst_any",   {31'b0, ifa.busy_any}, 32'h1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_reg4",  bus_a[31:0],  32'h0);
    chk("mid_rst_reg7",  bus_a[63:32], 32'h0);
    chk("mid_rst_b_reg4", bus_b[31:0], 32'h0);
    chk("mid_rst_busy",  {30'b0, ifa.busy}, 32'h0);
    chk("mid_rst_any",   {31'b0, ifa.busy_any}, 32'h0);
    drive(1, 8'd4, 4'hF, 32'd999, 2'b00, 8'd4, 8'd7, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 2'b11, 8'd4, 8'd7, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_a_reg4", bus_a[31:0], 32'h0);
    chk("post_rst_b_reg4", bus_b[31:0], 32'h0);

    // Random traffic against the array model, starting from a fresh reset.
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    model_clear();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      ld      = ($urandom_range(2) != 0);
      sel_ld  = sel_t'($urandom_range(19));
      be      = 4'($urandom);
      din     = $urandom;
      oe      = 2'($urandom);
      sel0    = sel_t'($urandom_range(19));
      sel1    = ($urandom_range(3) == 0) ? sel0 : sel_t'($urandom_range(19));
      reserve = ($urandom_range(2) == 0);
      sel_rsv = ($urandom_range(3) == 0) ? sel_ld : sel_t'($urandom_range(19));
      #1;
      chk($sformatf("rnd%0d_a0", n), bus_a[31:0],  exp_bus(oe[0], sel0, 1'b1));
      chk($sformatf("rnd%0d_a1", n), bus_a[63:32], exp_bus(oe[1], sel1, 1'b1));
      chk($sformatf("rnd%0d_b0", n), bus_b[31:0],  exp_bus(oe[0], sel0, 1'b0));
      chk($sformatf("rnd%0d_b1", n), bus_b[63:32], exp_bus(oe[1], sel1, 1'b0));
      chk($sformatf("rnd%0d_busy_a", n), {30'b0, ifa.busy}, {30'b0, exp_busy(sel1), exp_busy(sel0)});
      chk($sformatf("rnd%0d_busy_b", n), {30'b0, ifb.busy}, {30'b0, exp_busy(sel1), exp_busy(sel0)});
      chk($sformatf("rnd%0d_any_a", n), {31'b0, ifa.busy_any}, {31'b0, (m_busy != 16'h0)});
      chk($sformatf("rnd%0d_any_b", n), {31'b0, ifb.busy_any}, {31'b0, (m_busy != 16'h0)});
      @(posedge clk);
      model_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
